// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, RISC-V funct3 codes and size defaults for the load/store unit
package lsu_pkg;

    localparam int LSU_DATA_WIDTH    = 64;
    localparam int LSU_ADDRESS_WIDTH = 6;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // A request is bad when its offset is not aligned to its size, or its funct3 has no meaning
    function automatic logic req_is_bad(input logic write, input logic [2:0] funct3, input logic [2:0] offset);
        logic mis;
        mis = (funct3[1:0] == 2'b01 && offset[0]) ||
              (funct3[1:0] == 2'b10 && offset[1:0] != 2'b00) ||
              (funct3[1:0] == 2'b11 && offset != 3'b000);
        return mis || (write && funct3[2]) || (!write && funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and memory port bundle of the load/store unit
interface load_store_unit_if #(
    parameter int DATA_WIDTH    = lsu_pkg::LSU_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = lsu_pkg::LSU_ADDRESS_WIDTH
);
    logic                     req_valid;
    logic                     req_write;
    logic [2:0]               req_funct3;
    logic [ADDRESS_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0]    req_write_data;
    logic                     req_ready;
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic                     resp_error;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     memoryread;
    logic                     memorywrite;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_error, mem_address, mem_write_data, memoryread, memorywrite
    );

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_write_data, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_error, mem_address, mem_write_data, memoryread, memorywrite
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts and extends a load lane, and merges store data into a doubleword
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_dword,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [2:0]            i_funct3,
    input  logic [2:0]            i_offset,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_merged
);
    logic [5:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_size_mask;
    logic [DATA_WIDTH-1:0] w_mask;

    assign w_shift     = {i_offset, 3'b000};
    assign w_lane      = i_dword >> w_shift;
    assign w_size_mask = i_funct3[1:0] == 2'b00 ? DATA_WIDTH'(64'hFF) :
                         i_funct3[1:0] == 2'b01 ? DATA_WIDTH'(64'hFFFF) :
                         i_funct3[1:0] == 2'b10 ? DATA_WIDTH'(64'hFFFF_FFFF) : '1;
    assign w_mask      = w_size_mask << w_shift;

    // Load lane: sign-extend for LB/LH/LW, zero-extend for the unsigned forms, LD passes through
    always_comb begin
        o_load_data = w_lane;
        case (i_funct3)
            LB:      o_load_data = {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            LH:      o_load_data = {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            LW:      o_load_data = {{(DATA_WIDTH-32){w_lane[31]}}, w_lane[31:0]};
            LBU:     o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]};
            LHU:     o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]};
            LWU:     o_load_data = {{(DATA_WIDTH-32){1'b0}}, w_lane[31:0]};
            default: o_load_data = w_lane;
        endcase
    end

    assign o_merged = (i_dword & ~w_mask) | ((i_write_data << w_shift) & w_mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store unit with read-modify-write sub-doubleword stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = LSU_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = LSU_ADDRESS_WIDTH
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.slave  bus
);
    lsu_state_t               r_state;
    lsu_state_t               w_next;
    logic                     r_write;
    logic                     r_err;
    logic [2:0]               r_funct3;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_dword;
    logic                     w_accept;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic [DATA_WIDTH-1:0]    w_merged;

    assign w_accept = bus.req_valid && r_state == IDLE;

    // Latch the request on the accept cycle so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_funct3     <= 3'b000;
            r_address    <= '0;
            r_write_data <= '0;
        end else if (w_accept) begin
            r_write      <= bus.req_write;
            r_err        <= req_is_bad(bus.req_write, bus.req_funct3, bus.req_address[2:0]);
            r_funct3     <= bus.req_funct3;
            r_address    <= bus.req_address;
            r_write_data <= bus.req_write_data;
        end
    end

    // Capture the memory doubleword at the edge that ends READ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_dword <= '0;
        else if (r_state == READ) r_dword <= bus.mem_read_data;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: SD skips the read, narrower stores read-modify-write, errors go straight to RESP
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_accept ? IDLE :
                              req_is_bad(bus.req_write, bus.req_funct3, bus.req_address[2:0]) ? RESP :
                              (bus.req_write && bus.req_funct3 == SD) ? WRITE : READ;
            READ:    w_next = r_write ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state; all zero outside their active states so reset clears them at once
    always_comb begin
        bus.req_ready      = r_state == IDLE;
        bus.memoryread     = r_state == READ;
        bus.memorywrite    = r_state == WRITE;
        bus.mem_address    = (r_state == READ || r_state == WRITE) ? {r_address[ADDRESS_WIDTH-1:3], 3'b000} : '0;
        bus.mem_write_data = r_state == WRITE ? w_merged : '0;
        bus.resp_valid     = r_state == RESP;
        bus.resp_error     = r_state == RESP && r_err;
        bus.resp_data      = (r_state == RESP && !r_write && !r_err) ? w_load_data : '0;
    end

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
        .i_dword      (r_dword),
        .i_write_data (r_write_data),
        .i_funct3     (r_funct3),
        .i_offset     (r_address[2:0]),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged)
    );
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a 64-byte memory model
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));

    logic [63:0] mem [8];
    assign bus.mem_read_data = mem[bus.mem_address[5:3]];
    always @(posedge clk) if (bus.memorywrite) mem[bus.mem_address[5:3]] <= bus.mem_write_data;

    int n_chk = 0;
    int n_fail = 0;
    int lat, rd_n, wr_n;
    logic [63:0] r_data, w_addr, w_data;
    logic r_err;
    logic saw_resp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic wr, input logic [2:0] f3, input logic [5:0] addr, input logic [63:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_funct3 = f3;
        bus.req_address = addr;
        bus.req_write_data = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_funct3 = ~f3;
        bus.req_address = ~addr;
        bus.req_write_data = ~wd;
        lat = 0; rd_n = 0; wr_n = 0; r_data = 'x; r_err = 1'bx; w_addr = 'x; w_data = 'x;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_not_ready", 64'(bus.req_ready), 64'd0);
            rd_n += int'(bus.memoryread);
            if (bus.memorywrite) begin
                wr_n++;
                w_addr = 64'(bus.mem_address);
                w_data = bus.mem_write_data;
            end
            if (bus.resp_valid) begin
                lat = k;
                r_data = bus.resp_data;
                r_err = bus.resp_error;
            end
        end
        @(negedge clk);
        check("ready_after_resp", 64'(bus.req_ready), 64'd1);
        check("resp_single_pulse", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic expect_resp(input string tag, input logic [63:0] data, input logic err, input int l, input int rd, input int wr);
        check({tag, "_data"}, r_data, data);
        check({tag, "_err"}, 64'(r_err), 64'(err));
        check({tag, "_lat"}, 64'(lat), 64'(l));
        check({tag, "_rd"}, 64'(rd_n), 64'(rd));
        check({tag, "_wr"}, 64'(wr_n), 64'(wr));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 64'd0;
        mem[1] = 64'h0000_0000_0000_0002;
        mem[2] = 64'hDEAD_BEEF_0000_0000;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_address = '0;
        bus.req_write_data = '0;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_rd", 64'(bus.memoryread), 64'd0);
        check("rst_wr", 64'(bus.memorywrite), 64'd0);
        check("rst_addr", 64'(bus.mem_address), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        txn(1'b0, LD, 6'd8, 64'd0);
        expect_resp("ld8", 64'h0000_0000_0000_0002, 1'b0, 2, 1, 0);

        txn(1'b1, SB, 6'd9, 64'h1234_5678_9ABC_AAFF);
        expect_resp("sb9", 64'd0, 1'b0, 3, 1, 1);
        check("sb9_waddr", w_addr, 64'd8);
        check("sb9_wdata", w_data, 64'h0000_0000_0000_FF02);

        txn(1'b0, LB, 6'd9, 64'd0);
        expect_resp("lb9", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 1, 0);
        txn(1'b0, LBU, 6'd9, 64'd0);
        expect_resp("lbu9", 64'h0000_0000_0000_00FF, 1'b0, 2, 1, 0);

        txn(1'b1, SW, 6'd12, 64'h1234_5678_8000_0000);
        expect_resp("sw12", 64'd0, 1'b0, 3, 1, 1);
        check("sw12_wdata", w_data, 64'h8000_0000_0000_FF02);
        txn(1'b0, LW, 6'd12, 64'd0);
        expect_resp("lw12", 64'hFFFF_FFFF_8000_0000, 1'b0, 2, 1, 0);
        txn(1'b0, LWU, 6'd12, 64'd0);
        expect_resp("lwu12", 64'h0000_0000_8000_0000, 1'b0, 2, 1, 0);
        txn(1'b0, LH, 6'd14, 64'd0);
        expect_resp("lh14", 64'hFFFF_FFFF_FFFF_8000, 1'b0, 2, 1, 0);

        txn(1'b0, LW, 6'd2, 64'd0);
        expect_resp("lw2_mis", 64'd0, 1'b1, 1, 0, 0);
        txn(1'b1, SH, 6'd1, 64'hFFFF);
        expect_resp("sh1_mis", 64'd0, 1'b1, 1, 0, 0);
        txn(1'b1, 3'b100, 6'd0, 64'hFF);
        expect_resp("st_illegal", 64'd0, 1'b1, 1, 0, 0);
        txn(1'b0, 3'b111, 6'd0, 64'd0);
        expect_resp("ld_illegal", 64'd0, 1'b1, 1, 0, 0);
        txn(1'b1, SD, 6'd4, 64'h1);
        expect_resp("sd4_mis", 64'd0, 1'b1, 1, 0, 0);

        txn(1'b1, SD, 6'd56, 64'h1122_3344_5566_7788);
        expect_resp("sd56", 64'd0, 1'b0, 2, 0, 1);
        check("sd56_waddr", w_addr, 64'd56);
        check("sd56_wdata", w_data, 64'h1122_3344_5566_7788);
        txn(1'b0, LHU, 6'd62, 64'd0);
        expect_resp("lhu62", 64'h0000_0000_0000_1122, 1'b0, 2, 1, 0);
        txn(1'b0, LD, 6'd56, 64'd0);
        expect_resp("ld56", 64'h1122_3344_5566_7788, 1'b0, 2, 1, 0);
        txn(1'b0, LH, 6'd60, 64'd0);
        expect_resp("lh60", 64'h0000_0000_0000_3344, 1'b0, 2, 1, 0);
        txn(1'b0, LB, 6'd56, 64'd0);
        expect_resp("lb56", 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 1, 0);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_funct3 = SB;
        bus.req_address = 6'd16;
        bus.req_write_data = 64'h55;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstw_read_phase", 64'(bus.memoryread), 64'd1);
        @(negedge clk);
        check("rstw_write_phase", 64'(bus.memorywrite), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstw_wr_drop", 64'(bus.memorywrite), 64'd0);
        check("rstw_ready", 64'(bus.req_ready), 64'd1);
        check("rstw_addr", 64'(bus.mem_address), 64'd0);
        check("rstw_wdata", bus.mem_write_data, 64'd0);
        saw_resp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_resp = saw_resp | bus.resp_valid;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_resp = saw_resp | bus.resp_valid;
        end
        check("rstw_no_resp", 64'(saw_resp), 64'd0);
        check("rstw_mem_kept", mem[2], 64'hDEAD_BEEF_0000_0000);
        txn(1'b0, LD, 6'd16, 64'd0);
        expect_resp("ld16_after_rst", 64'hDEAD_BEEF_0000_0000, 1'b0, 2, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: DATA_WIDTH, 64, data width in bits; ADDRESS_WIDTH, 6, byte-address width.
REQ-002 Ports, clock and reset first: clk, input, 1, sole clock, rising edge; reset, input, 1, asynchronous active-high reset.
REQ-003 Core-side inputs:
- req_valid, input, 1, request present.
- req_write, input, 1, store=1, load=0.
- req_funct3, input, 3, RISC-V width/sign code.
- req_address, input, ADDRESS_WIDTH, byte address.
- req_write_data, input, DATA_WIDTH, store data, right-justified.
REQ-004 Core-side outputs:
- req_ready, output, 1, unit idle.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_data, output, DATA_WIDTH, extended load data.
- resp_error, output, 1, misaligned or illegal request.
REQ-005 Memory-side ports:
- mem_address, output, ADDRESS_WIDTH, doubleword-aligned byte address.
- mem_write_data, output, DATA_WIDTH, merged store data.
- memoryread, output, 1, read strobe.
- memorywrite, output, 1, write strobe.
- mem_read_data, input, DATA_WIDTH, combinational little-endian read data.

Function
REQ-006 The unit SHALL accept a request only on a cycle with req_valid=1 and req_ready=1, and req_ready SHALL be 1 only in state IDLE.
REQ-007 The accept cycle SHALL latch req_write, req_funct3, req_address and req_write_data; later changes on the request inputs SHALL be ignored.
REQ-008 FSM states: IDLE, READ, WRITE, RESP.
REQ-009 FSM transitions from IDLE on accept:
- misaligned or illegal request -> RESP.
- load -> READ.
- store with funct3 SD -> WRITE.
- SB, SH or SW store -> READ.
REQ-010 FSM transitions after IDLE: READ -> RESP for a load, READ -> WRITE for a store, WRITE -> RESP, RESP -> IDLE.
REQ-011 mem_address SHALL equal the latched address with bits [2:0] forced to 0 in READ and WRITE, and SHALL be 0 elsewhere.
REQ-012 memoryread SHALL be 1 only in READ, and the READ state SHALL capture mem_read_data into an internal doubleword register at the clock edge that ends READ.
REQ-013 memorywrite SHALL be 1 only in WRITE, and mem_write_data SHALL be the captured doubleword with the addressed lane(s) replaced by the low 8, 16 or 32 bits of store data. For SD the replacement is the full 64-bit store data.
REQ-014 Loads SHALL extract the lane at byte offset address[2:0] from the captured doubleword. LB, LH and LW SHALL sign-extend to 64 bits; LBU, LHU and LWU SHALL zero-extend; LD SHALL pass the lane through unchanged.
REQ-015 A request is misaligned when:
- a halfword access has address[0]≠0;
- a word access has address[1:0]≠0;
- a doubleword access has address[2:0]≠0.
REQ-016 Store funct3 values 3'b100 to 3'b111 and load funct3 3'b111 are illegal.
REQ-017 A misaligned or illegal request SHALL assert neither memoryread nor memorywrite, and SHALL respond with resp_error=1 and resp_data=0.
REQ-018 In RESP, resp_valid SHALL be 1 for exactly one cycle. resp_data SHALL carry load data for a load and 0 for a store. resp_error SHALL be 0 unless REQ-017 applies.
REQ-019 Latency from the accept edge to resp_valid:
- load: 2 cycles.
- SD: 2 cycles.
- SB, SH or SW: 3 cycles.
- error: 1 cycle.
REQ-020 Aligned doubleword accesses SHALL never wrap past address 2**ADDRESS_WIDTH-1.
REQ-021 A new request SHALL NOT be accepted in the cycle where resp_valid=1, so there are no back-to-back overlaps.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- clear the latched request and the captured doubleword;
- drive req_ready=1 and every other output to 0.
REQ-023 If reset is asserted in WRITE before the clock edge, memorywrite SHALL drop immediately and no memory write SHALL occur.
REQ-024 Reset in any state SHALL discard the transaction with no response.

Structure
REQ-025 Package lsu_pkg SHALL hold the state enum, the funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD) and the DATA_WIDTH and ADDRESS_WIDTH defaults.
REQ-026 Lane extract/extend and lane merge SHALL live in one combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-027 With memory preloaded so that byte 8 = 0x02, LD at address 8: the response SHALL come at accept+2 with resp_data=0x0000000000000002, resp_error=0, and memoryread high for exactly 1 cycle.
REQ-028 SB of data 0xFF at address 9 SHALL pulse memorywrite once with mem_address=8 and mem_write_data=0x000000000000FF02. A following LB at address 9 SHALL return 0xFFFFFFFFFFFFFFFF, and LBU at address 9 SHALL return 0x00000000000000FF.
REQ-029 LW at address 2 SHALL respond at accept+1 with resp_error=1 and resp_data=0, with no memoryread or memorywrite pulse.
REQ-030 SD of 0x1122334455667788 at address 56 followed by LHU at address 62 SHALL return 0x0000000000001122.
REQ-031 Reset asserted mid-cycle while in WRITE: memorywrite SHALL fall at once, the memory contents SHALL be unchanged, req_ready=1, and resp_valid SHALL never pulse.
